// File: rtl/knock_seq_unlock.sv
// knock_seq_unlock
//   Bus-snooping unlock sequencer. Qualified read accesses inside an address
//   window carry a key field; a fixed sequence of SEQ_LEN keys opens the block.
//   While open, every read (other than CLOSE_KEY) returns the next bit of an
//   LFSR on sdrd. CLOSE_KEY or an inactivity timeout relocks the block.
//
//   State table:
//     IDLE (0) | waiting for the first key of the sequence
//     SEEK (1) | part of the sequence matched, idx = next entry expected
//     OPEN (2) | unlocked, reads shift out LFSR bits
//     3        | illegal, returns to IDLE on the next clock
//
// Ports
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   sel_n     device select, active low
//   ba        address bus (window select in the top two bits, key at KEY_LSB)
//   br_w      1 = read cycle
//   oe        enables state_q / lfsr_q observation (else driven 0)
//   sdrd      serial data read bit (registered)
//   sdrd_en   sdrd drive enable (combinational, same cycle as the access)
//   unlocked  1 while in OPEN (registered)
//   state_q   FSM state, gated by oe
//   lfsr_q    LFSR contents, gated by oe
module knock_seq_unlock #(
  parameter int                         ADDR_W    = 14,
  parameter logic [1:0]                 WIN_HI    = 2'b01,
  parameter int                         KEY_LSB   = 4,
  parameter int                         KEY_W     = 4,
  parameter int                         SEQ_LEN   = 4,
  parameter logic [SEQ_LEN*KEY_W-1:0]   SEQ_KEYS  = 16'h5A3C,
  parameter logic [KEY_W-1:0]           CLOSE_KEY = 4'hF,
  parameter int                         LFSR_W    = 6,
  parameter logic [LFSR_W-1:0]          LFSR_TAPS = 6'b100001,
  parameter logic [LFSR_W-1:0]          LFSR_SEED = 6'b000001,
  parameter int                         TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel_n,
  input  logic [ADDR_W-1:0] ba,
  input  logic              br_w,
  input  logic              oe,
  output logic              sdrd,
  output logic              sdrd_en,
  output logic              unlocked,
  output logic [1:0]        state_q,
  output logic [LFSR_W-1:0] lfsr_q
);

  localparam int IDX_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [KEY_W-1:0] KEY0 = SEQ_KEYS[KEY_W-1:0];

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEEK = 2'd1,
    S_OPEN = 2'd2
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   idle_cnt;
  logic [LFSR_W-1:0]  lfsr;

  logic               acc;
  logic [KEY_W-1:0]   key;
  logic [KEY_W-1:0]   key_exp;
  logic               is_last;
  logic               lfsr_fb;
  logic [CNT_W-1:0]   cnt_inc;
  logic               timeout_hit;
  logic               unused_ba;

  assign acc       = ~sel_n & br_w & (ba[ADDR_W-1:ADDR_W-2] == WIN_HI);
  assign key       = ba[KEY_LSB +: KEY_W];
  assign unused_ba = ^ba;

  always_comb begin
    key_exp = KEY0;
    for (int i = 0; i < SEQ_LEN; i++) begin
      if (idx == IDX_W'(i)) key_exp = SEQ_KEYS[i*KEY_W +: KEY_W];
    end
  end

  assign is_last = (idx == IDX_W'(SEQ_LEN - 1));

  // An all-zero register would lock up the LFSR; force a 1 in so it recovers.
  assign lfsr_fb = (lfsr == '0) ? 1'b1 : ^(lfsr & LFSR_TAPS);

  assign cnt_inc     = (idle_cnt == CNT_W'(TIMEOUT)) ? idle_cnt : idle_cnt + CNT_W'(1);
  assign timeout_hit = (cnt_inc == CNT_W'(TIMEOUT));

  assign sdrd_en = acc & (state == S_OPEN) & (key != CLOSE_KEY);
  assign state_q = oe ? state : 2'd0;
  assign lfsr_q  = oe ? lfsr : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      idx      <= '0;
      idle_cnt <= '0;
      lfsr     <= LFSR_SEED;
      sdrd     <= 1'b0;
      unlocked <= 1'b0;
    end else begin
      // Inactivity counter only runs in SEEK/OPEN; an access always restarts it.
      if (acc || !(state == S_SEEK || state == S_OPEN) || timeout_hit)
        idle_cnt <= '0;
      else
        idle_cnt <= cnt_inc;

      case (state)
        S_IDLE: begin
          if (acc && key == KEY0) begin
            state <= S_SEEK;
            idx   <= IDX_W'(1);
          end
        end

        S_SEEK: begin
          if (acc) begin
            if (key == key_exp) begin
              if (is_last) begin
                state    <= S_OPEN;
                idx      <= '0;
                lfsr     <= LFSR_SEED;
                unlocked <= 1'b1;
              end else begin
                idx <= idx + IDX_W'(1);
              end
            end else if (key == KEY0) begin
              // A wrong key that is itself the first entry restarts the sequence.
              idx <= IDX_W'(1);
            end else begin
              state <= S_IDLE;
              idx   <= '0;
            end
          end else if (timeout_hit) begin
            state <= S_IDLE;
            idx   <= '0;
          end
        end

        S_OPEN: begin
          if (acc) begin
            if (key == CLOSE_KEY) begin
              state    <= S_IDLE;
              idx      <= '0;
              unlocked <= 1'b0;
            end else begin
              sdrd <= lfsr[0];
              lfsr <= {lfsr_fb, lfsr[LFSR_W-1:1]};
            end
          end else if (timeout_hit) begin
            state    <= S_IDLE;
            idx      <= '0;
            unlocked <= 1'b0;
          end
        end

        default: begin
          state    <= S_IDLE;
          idx      <= '0;
          unlocked <= 1'b0;
        end
      endcase
    end
  end

endmodule
